// File: rtl/gps_sample_packer.sv
// gps_sample_packer: packs 2-bit I/Q samples into framed words on a valid/ready stream with drop counting
module gps_sample_packer #(
  parameter int SPW = 4,
  parameter int FRAME_WORDS = 64,
  parameter logic [4*SPW-1:0] SYNC_WORD = 16'h1ACF
) (
  input  logic               GPS_CLK_16_368,
  input  logic               RESET_N,
  input  logic               GPS_I0,
  input  logic               GPS_I1,
  input  logic               GPS_Q0,
  input  logic               GPS_Q1,
  input  logic               ENABLE,
  output logic [4*SPW-1:0]   OUT_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               OUT_SOF,
  output logic               OVERFLOW
);
  localparam int W = 4 * SPW;
  localparam int H = W / 2;
  localparam int CW = $clog2(SPW);
  typedef enum logic [1:0] {IDLE, SYNC, SEQ, DATA} state_t;
  state_t r_state;
  logic [W-5:0] r_sh;
  logic [W-1:0] r_pend;
  logic r_pend_v;
  logic [CW-1:0] r_scnt;
  logic [H-1:0] r_seq, r_drop;
  logic [15:0] r_wcnt;
  logic [W-1:0] w_word;
  logic [H-1:0] w_drop_inc;
  logic w_free, w_done, w_take, w_drop;
  always_comb begin
    w_word = {r_sh, GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    w_free = !OUT_VALID || OUT_READY;
    w_done = ENABLE && r_state != IDLE && r_scnt == CW'(SPW - 1);
    w_take = ENABLE && r_state == DATA && w_free && r_pend_v;
    w_drop = w_done && r_pend_v && !w_take;
    w_drop_inc = r_drop + H'(r_drop != '1);
  end
  always_ff @(posedge GPS_CLK_16_368) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_sh <= '0;
      r_pend <= '0;
      r_pend_v <= 1'b0;
      r_scnt <= '0;
      r_seq <= '0;
      r_drop <= '0;
      r_wcnt <= '0;
      OUT_DATA <= '0;
      OUT_VALID <= 1'b0;
      OUT_SOF <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      if (OUT_VALID && OUT_READY) OUT_VALID <= 1'b0;
      if (!ENABLE) begin
        r_state <= IDLE;
        r_pend_v <= 1'b0;
        r_scnt <= '0;
      end else begin
        if (r_state != IDLE) begin
          r_sh <= w_word[W-5:0];
          r_scnt <= w_done ? '0 : r_scnt + 1'b1;
        end
        if (w_drop) begin
          r_drop <= w_drop_inc;
          OVERFLOW <= 1'b1;
        end else if (w_done) begin
          r_pend <= w_word;
          r_pend_v <= 1'b1;
        end else if (w_take) begin
          r_pend_v <= 1'b0;
        end
        if (r_state == IDLE) begin
          r_state <= SYNC;
        end else if (w_free && r_state == SYNC) begin
          OUT_DATA <= SYNC_WORD;
          OUT_SOF <= 1'b1;
          OUT_VALID <= 1'b1;
          r_state <= SEQ;
        end else if (w_free && r_state == SEQ) begin
          OUT_DATA <= {r_seq, r_drop};
          OUT_SOF <= 1'b0;
          OUT_VALID <= 1'b1;
          r_drop <= H'(w_drop);
          r_wcnt <= '0;
          r_state <= DATA;
        end else if (w_take) begin
          OUT_DATA <= r_pend;
          OUT_SOF <= 1'b0;
          OUT_VALID <= 1'b1;
          r_wcnt <= r_wcnt + 1'b1;
          if (r_wcnt == 16'(FRAME_WORDS - 1)) begin
            r_seq <= r_seq + 1'b1;
            r_state <= SYNC;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_gps_sample_packer.sv
// tb_gps_sample_packer: directed stimulus with a queue-based reference model and literal stream checks
module tb_gps_sample_packer;
  localparam int M_IDLE = 0;
  localparam int M_SYNC = 1;
  localparam int M_SEQ = 2;
  localparam int M_DATA = 3;
  logic clk = 1'b0;
  logic rst_n, i0, i1, q0, q1, en, rdy;
  logic [15:0] od [2];
  logic ov [2];
  logic os [2];
  logic oo [2];
  int vec = 0;
  int miss = 0;
  bit started = 1'b0;
  logic [16:0] acc [$];
  logic [7:0] wseq [$];
  logic w_prev_sof = 1'b0;
  logic [3:0] nibs [$];
  int m_mode [2];
  int m_words [2];
  logic m_v [2];
  logic m_sof [2];
  logic m_ovf [2];
  logic m_pv [2];
  logic [15:0] m_d [2];
  logic [15:0] m_pw [2];
  logic [7:0] m_seq [2];
  logic [7:0] m_drop [2];
  logic [15:0] held;
  gps_sample_packer #(.SPW(4), .FRAME_WORDS(4), .SYNC_WORD(16'h1ACF)) u_main (
    .GPS_CLK_16_368(clk), .RESET_N(rst_n), .GPS_I0(i0), .GPS_I1(i1), .GPS_Q0(q0), .GPS_Q1(q1),
    .ENABLE(en), .OUT_DATA(od[0]), .OUT_VALID(ov[0]), .OUT_READY(rdy), .OUT_SOF(os[0]), .OVERFLOW(oo[0])
  );
  gps_sample_packer #(.SPW(4), .FRAME_WORDS(1), .SYNC_WORD(16'h1ACF)) u_wrap (
    .GPS_CLK_16_368(clk), .RESET_N(rst_n), .GPS_I0(i0), .GPS_I1(i1), .GPS_Q0(q0), .GPS_Q1(q1),
    .ENABLE(en), .OUT_DATA(od[1]), .OUT_VALID(ov[1]), .OUT_READY(rdy), .OUT_SOF(os[1]), .OVERFLOW(oo[1])
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    logic [3:0] nib;
    logic [15:0] nw;
    logic got, room;
    nib = {i1, i0, q1, q0};
    nw = '0;
    got = 1'b0;
    if (!rst_n) begin
      nibs.delete();
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_words[k] = 0; m_v[k] = 0; m_sof[k] = 0; m_ovf[k] = 0;
        m_pv[k] = 0; m_d[k] = '0; m_pw[k] = '0; m_seq[k] = '0; m_drop[k] = '0;
      end
    end else begin
      if (!en) nibs.delete();
      else if (m_mode[0] != M_IDLE) begin
        nibs.push_back(nib);
        if (nibs.size() == 4) begin
          foreach (nibs[i]) nw = {nw[11:0], nibs[i]};
          got = 1'b1;
          nibs.delete();
        end
      end
      for (int k = 0; k < 2; k++) begin
        room = !m_v[k] || rdy;
        if (m_v[k] && rdy) m_v[k] = 1'b0;
        if (!en) begin
          m_mode[k] = M_IDLE;
          m_pv[k] = 1'b0;
        end else if (m_mode[k] == M_IDLE) begin
          m_mode[k] = M_SYNC;
        end else begin
          if (room && m_mode[k] == M_SYNC) begin
            m_d[k] = 16'h1ACF; m_sof[k] = 1; m_v[k] = 1; m_mode[k] = M_SEQ;
          end else if (room && m_mode[k] == M_SEQ) begin
            m_d[k] = {m_seq[k], m_drop[k]}; m_sof[k] = 0; m_v[k] = 1;
            m_drop[k] = '0; m_words[k] = 0; m_mode[k] = M_DATA;
          end else if (room && m_mode[k] == M_DATA && m_pv[k]) begin
            m_d[k] = m_pw[k]; m_sof[k] = 0; m_v[k] = 1; m_pv[k] = 0;
            m_words[k]++;
            if (m_words[k] == ((k == 0) ? 4 : 1)) begin
              m_seq[k]++;
              m_mode[k] = M_SYNC;
            end
          end
          if (got) begin
            if (m_pv[k]) begin
              if (m_drop[k] != 8'hFF) m_drop[k]++;
              m_ovf[k] = 1'b1;
            end else begin
              m_pv[k] = 1'b1;
              m_pw[k] = nw;
            end
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        vec++;
        if ({ov[k], os[k], oo[k], od[k]} !== {m_v[k], m_sof[k], m_ovf[k], m_d[k]}) begin
          miss++;
          $display("FAIL model_dut%0d t=%0t: got v=%b sof=%b ovf=%b data=%h, want v=%b sof=%b ovf=%b data=%h",
                   k, $time, ov[k], os[k], oo[k], od[k], m_v[k], m_sof[k], m_ovf[k], m_d[k]);
        end
      end
    end
    if (ov[0] && rdy) acc.push_back({os[0], od[0]});
    if (!rst_n) w_prev_sof = 1'b0;
    else if (ov[1] && rdy) begin
      if (w_prev_sof) wseq.push_back(od[1][15:8]);
      w_prev_sof = os[1];
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic set_nib(input logic [3:0] n);
    {i1, i0, q1, q0} = n;
  endtask
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  function automatic int nseq();
    int c = 0;
    for (int i = 1; i < acc.size(); i++) if (acc[i-1][16]) c++;
    return c;
  endfunction
  function automatic logic [15:0] seq_word(input int w);
    int c = 0;
    for (int i = 1; i < acc.size(); i++) begin
      if (acc[i-1][16]) begin
        if (c == w) return acc[i][15:0];
        c++;
      end
    end
    return 16'hXXXX;
  endfunction
  initial begin
    rst_n = 1'b0; en = 1'b1; rdy = 1'b1; set_nib(4'hB);
    tick();
    started = 1'b1;
    tick();
    tick();
    check("rst_valid", ov[0], 0);
    check("rst_data", od[0], 0);
    check("rst_sof", os[0], 0);
    check("rst_ovf", oo[0], 0);
    rst_n = 1'b1;
    acc.delete();
    for (int n = 0; n < 200 && acc.size() < 9; n++) tick();
    check("const_len", acc.size() >= 9, 1);
    check("const_w0", acc[0], {1'b1, 16'h1ACF});
    check("const_w1", acc[1], {1'b0, 16'h0000});
    for (int i = 2; i < 6; i++) check("const_data", acc[i], {1'b0, 16'hBBBB});
    check("const_w6", acc[6], {1'b1, 16'h1ACF});
    check("const_w7", acc[7], {1'b0, 16'h0100});
    check("const_w8", acc[8], {1'b0, 16'hBBBB});
    check("const_ovf", oo[0], 0);
    rst_n = 1'b0; en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    acc.delete();
    en = 1'b1; set_nib(4'hF);
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_nib(4'(i));
      tick();
    end
    set_nib(4'h6);
    for (int n = 0; n < 50 && acc.size() < 3; n++) tick();
    check("order_sync", acc[0], {1'b1, 16'h1ACF});
    check("order_seq", acc[1], {1'b0, 16'h0000});
    check("order_word", acc[2], {1'b0, 16'h1234});
    acc.delete();
    for (int n = 0; n < 200 && !(acc.size() >= 3 && !ov[0] && acc[acc.size()-3][16] && !acc[acc.size()-1][16]); n++) tick();
    check("stall_align", acc.size() >= 3 && !ov[0], 1);
    rdy = 1'b0;
    tick();
    tick();
    tick();
    held = od[0];
    check("stall_valid", ov[0], 1);
    for (int i = 0; i < 17; i++) begin
      tick();
      check("stall_data", od[0], held);
    end
    check("stall_ovf", oo[0], 1);
    acc.delete();
    rdy = 1'b1;
    for (int n = 0; n < 300 && nseq() < 2; n++) tick();
    check("stall_nseq", nseq() >= 2, 1);
    check("stall_drops", seq_word(0) & 16'h00FF, 3);
    check("stall_drops_next", seq_word(1) & 16'h00FF, 0);
    rst_n = 1'b0; set_nib(4'hB);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 34; i++) tick();
    check("en_pre_valid", ov[0], 1);
    check("en_pre_data", od[0], 16'hBBBB);
    acc.delete();
    rdy = 1'b0; set_nib(4'h7);
    tick();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1; rdy = 1'b1; set_nib(4'h5);
    for (int n = 0; n < 50 && acc.size() < 4; n++) tick();
    check("en_held", acc[0], {1'b0, 16'hBBBB});
    check("en_sync", acc[1], {1'b1, 16'h1ACF});
    check("en_seq", acc[2], {1'b0, 16'h0200});
    check("en_data", acc[3], {1'b0, 16'h5555});
    rst_n = 1'b0; set_nib(4'hB);
    tick();
    tick();
    wseq.delete();
    rst_n = 1'b1;
    for (int n = 0; n < 3000 && wseq.size() < 257; n++) tick();
    check("wrap_len", wseq.size() >= 257, 1);
    check("wrap_first", wseq[0], 8'h00);
    check("wrap_255", wseq[255], 8'hFF);
    check("wrap_256", wseq[256], 8'h00);
    check("wrap_ovf", oo[1], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
